iter_divider: RTL and testbench

//  Multi-cycle 32-bit signed/unsigned integer divider. Serves as the responder on the
//  EX-stage divide interface (div_en/div_sign/divisor/dividend -> quotient/remainder/complete).

---
 rtl/iter_divider.sv | 130 +++++++++++++
 tb/tb_iter_divider.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/iter_divider.sv
// Multi-cycle radix-2 restoring integer divider (signed/unsigned) for the EX-stage
// divide interface: DATA_W iterations on operand magnitudes, then one sign-fix cycle.
module iter_divider #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              div_en_i,
  input  logic              div_sign_i,
  input  logic [DATA_W-1:0] dividend_i,
  input  logic [DATA_W-1:0] divisor_i,
  input  logic              div_ack_i,
  input  logic              flush_i,
  output logic [DATA_W-1:0] quotient_o,
  output logic [DATA_W-1:0] remainder_o,
  output logic              div_complete_o
);

  typedef enum logic [1:0] {IDLE, BUSY, FIX, DONE} state_t;

  state_t              state_q, state_d;
  logic                sign_q, sign_d;
  logic                dvd_neg_q, dvd_neg_d;
  logic                dvs_neg_q, dvs_neg_d;
  logic [DATA_W:0]     rem_q, rem_d;
  logic [DATA_W-1:0]   quo_q, quo_d;
  logic [DATA_W-1:0]   dvs_q, dvs_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   quotient_q, quotient_d;
  logic [DATA_W-1:0]   remainder_q, remainder_d;

  logic [DATA_W-1:0]   dvd_abs, dvs_abs;
  logic [DATA_W+1:0]   rem_sh, trial;
  logic                trial_ok, neg_q, neg_r;

  always_comb begin
    state_d     = state_q;
    sign_d      = sign_q;
    dvd_neg_d   = dvd_neg_q;
    dvs_neg_d   = dvs_neg_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    dvs_d       = dvs_q;
    cnt_d       = cnt_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;

    // Magnitudes are only taken in signed mode; 0x8000_0000 stays as-is and is
    // correct when read back as an unsigned magnitude.
    dvd_abs = (div_sign_i && dividend_i[DATA_W-1]) ? -dividend_i : dividend_i;
    dvs_abs = (div_sign_i && divisor_i[DATA_W-1])  ? -divisor_i  : divisor_i;

    rem_sh   = {rem_q, quo_q[DATA_W-1]};
    trial    = rem_sh - {2'b00, dvs_q};
    trial_ok = ~trial[DATA_W+1];

    neg_q = sign_q & (dvd_neg_q ^ dvs_neg_q) & (dvs_q != '0);
    neg_r = sign_q & dvd_neg_q;

    if (flush_i) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (div_en_i) begin
            state_d   = BUSY;
            sign_d    = div_sign_i;
            dvd_neg_d = dividend_i[DATA_W-1];
            dvs_neg_d = divisor_i[DATA_W-1];
            quo_d     = dvd_abs;
            dvs_d     = dvs_abs;
            rem_d     = '0;
            cnt_d     = '0;
          end
        end
        BUSY: begin
          rem_d = trial_ok ? trial[DATA_W:0] : rem_sh[DATA_W:0];
          quo_d = {quo_q[DATA_W-2:0], trial_ok};
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(DATA_W-1)) begin
            state_d = FIX;
          end
        end
        FIX: begin
          quotient_d  = neg_q ? -quo_q : quo_q;
          remainder_d = neg_r ? -rem_q[DATA_W-1:0] : rem_q[DATA_W-1:0];
          state_d     = DONE;
        end
        DONE: begin
          if (div_ack_i) begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      sign_q      <= 1'b0;
      dvd_neg_q   <= 1'b0;
      dvs_neg_q   <= 1'b0;
      rem_q       <= '0;
      quo_q       <= '0;
      dvs_q       <= '0;
      cnt_q       <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
    end else begin
      state_q     <= state_d;
      sign_q      <= sign_d;
      dvd_neg_q   <= dvd_neg_d;
      dvs_neg_q   <= dvs_neg_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      dvs_q       <= dvs_d;
      cnt_q       <= cnt_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
    end
  end

  assign quotient_o     = quotient_q;
  assign remainder_o    = remainder_q;
  assign div_complete_o = (state_q == DONE);

endmodule

// File: tb/tb_iter_divider.sv
// Directed scoreboard bench for iter_divider: expected results are queued at start
// and popped when div_complete_o rises.
module tb_iter_divider;

  localparam int W = 32;

  logic          clk;
  logic          rst;
  logic          div_en;
  logic          div_sign;
  logic [W-1:0]  dividend;
  logic [W-1:0]  divisor;
  logic          div_ack;
  logic          flush;
  logic [W-1:0]  quotient;
  logic [W-1:0]  remainder;
  logic          div_complete;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
  } exp_t;

  exp_t         sb[$];
  int           compared   = 0;
  int           mismatched = 0;
  int           edge_cnt   = 0;
  int           start_edge = 0;
  logic [W-1:0] last_q     = '0;
  logic [W-1:0] last_r     = '0;

  iter_divider #(.DATA_W(W), .CNT_W(6)) dut (
    .clk            (clk),
    .rst            (rst),
    .div_en_i       (div_en),
    .div_sign_i     (div_sign),
    .dividend_i     (dividend),
    .divisor_i      (divisor),
    .div_ack_i      (div_ack),
    .flush_i        (flush),
    .quotient_o     (quotient),
    .remainder_o    (remainder),
    .div_complete_o (div_complete)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    edge_cnt++;
  endtask

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Independent reference using the simulator's own integer division.
  function automatic exp_t model(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    if (b == '0) begin
      e.q = '1;
      e.r = a;
    end else if (sgn) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
        e.q = 32'h8000_0000;
        e.r = '0;
      end else begin
        e.q = W'($signed(a) / $signed(b));
        e.r = W'($signed(a) % $signed(b));
      end
    end else begin
      e.q = a / b;
      e.r = a % b;
    end
    return e;
  endfunction

  // Presents an operation, pushes its expected result, takes the start edge and
  // then scrambles the operands to prove they were sampled only on that edge.
  task automatic applyStimulus(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b,
                               input logic [W-1:0] eq, input logic [W-1:0] er);
    exp_t e;
    e.q      = eq;
    e.r      = er;
    sb.push_back(e);
    div_en   = 1'b1;
    div_sign = sgn;
    dividend = a;
    divisor  = b;
    tick();
    start_edge = edge_cnt;
    dividend = $urandom;
    divisor  = $urandom;
    div_sign = ~sgn;
  endtask

  task automatic checkOutput(input string tag, input bit chk_lat);
    int   n;
    exp_t e;
    n = 0;
    while (div_complete !== 1'b1 && n < 60) begin
      tick();
      n++;
    end
    check({tag, "_complete"}, {31'b0, div_complete}, 32'd1);
    if (chk_lat) begin
      check({tag, "_latency"}, W'(edge_cnt - start_edge + 1), 32'd34);
    end
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check({tag, "_q"}, quotient, e.q);
      check({tag, "_r"}, remainder, e.r);
      last_q = e.q;
      last_r = e.r;
    end
  endtask

  task automatic ackResult(input string tag);
    div_ack = 1'b1;
    div_en  = 1'b0;
    tick();
    div_ack = 1'b0;
    check({tag, "_ack_drop"}, {31'b0, div_complete}, 32'd0);
  endtask

  task automatic watchNoComplete(input string tag, input int cycles);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < cycles; k++) begin
      tick();
      if (div_complete !== 1'b0) seen = 1'b1;
    end
    check({tag, "_no_complete"}, {31'b0, seen}, 32'd0);
  endtask

  initial begin
    exp_t e;
    rst      = 1'b1;
    div_en   = 1'b0;
    div_sign = 1'b0;
    dividend = '0;
    divisor  = '0;
    div_ack  = 1'b0;
    flush    = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    check("reset_complete", {31'b0, div_complete}, 32'd0);
    check("reset_q", quotient, 32'd0);
    check("reset_r", remainder, 32'd0);

    // Unsigned 100/7 with exact latency.
    applyStimulus(1'b0, 32'd100, 32'd7, 32'd14, 32'd2);
    checkOutput("t1", 1'b1);
    ackResult("t1");

    // Signed -7/2, with a stray ack during BUSY that must be ignored.
    applyStimulus(1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
    repeat (5) tick();
    div_ack = 1'b1;
    tick();
    div_ack = 1'b0;
    check("busy_no_complete", {31'b0, div_complete}, 32'd0);
    checkOutput("neg7_2", 1'b1);
    ackResult("neg7_2");

    applyStimulus(1'b1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1);
    checkOutput("7_neg2", 1'b0);
    ackResult("7_neg2");

    // Divide by zero in both modes.
    applyStimulus(1'b1, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF, 32'h1234_5678);
    checkOutput("div0_s", 1'b1);
    ackResult("div0_s");
    applyStimulus(1'b0, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF, 32'h1234_5678);
    checkOutput("div0_u", 1'b0);
    ackResult("div0_u");

    // Signed overflow and unsigned full-range.
    applyStimulus(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0);
    checkOutput("ovf", 1'b0);
    ackResult("ovf");
    applyStimulus(1'b0, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0);
    checkOutput("umax", 1'b0);
    ackResult("umax");

    // Mixed random operands against the reference model.
    for (int i = 0; i < 6; i++) begin
      logic [W-1:0] a, b;
      logic         sgn;
      a   = $urandom;
      b   = (i % 3 == 0) ? W'($urandom_range(1, 255)) : W'($urandom);
      sgn = 1'(i % 2);
      e   = model(sgn, a, b);
      applyStimulus(sgn, a, b, e.q, e.r);
      checkOutput("rand", 1'b0);
      ackResult("rand");
    end

    // Stall in DONE, then ack with en still high and new operands already presented.
    applyStimulus(1'b0, 32'hDEAD_BEEF, 32'h10, 32'h0DEA_DBEE, 32'h0000_000F);
    checkOutput("stall", 1'b0);
    for (int k = 0; k < 5; k++) begin
      tick();
      check("stall_complete", {31'b0, div_complete}, 32'd1);
      check("stall_q", quotient, last_q);
      check("stall_r", remainder, last_r);
    end
    div_en   = 1'b1;
    div_sign = 1'b1;
    dividend = 32'hFFFF_FFF9;
    divisor  = 32'd2;
    div_ack  = 1'b1;
    tick();
    div_ack = 1'b0;
    check("stall_ack_drop", {31'b0, div_complete}, 32'd0);
    applyStimulus(1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
    checkOutput("restart", 1'b1);
    ackResult("restart");

    // Flush at iteration 10: no completion, outputs keep their last value.
    applyStimulus(1'b0, 32'd1000, 32'd3, 32'd333, 32'd1);
    repeat (10) tick();
    flush  = 1'b1;
    div_en = 1'b0;
    tick();
    flush = 1'b0;
    void'(sb.pop_back());
    check("flush_complete", {31'b0, div_complete}, 32'd0);
    check("flush_q_kept", quotient, last_q);
    check("flush_r_kept", remainder, last_r);
    watchNoComplete("flush", 40);

    // Flush together with en in IDLE must not start an operation.
    div_en   = 1'b1;
    flush    = 1'b1;
    dividend = 32'd5;
    divisor  = 32'd1;
    tick();
    flush  = 1'b0;
    div_en = 1'b0;
    watchNoComplete("flush_idle", 40);

    // Normal op to leave non-zero outputs, then reset while in FIX.
    applyStimulus(1'b0, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0);
    checkOutput("pre_rst", 1'b0);
    ackResult("pre_rst");
    applyStimulus(1'b1, 32'hFFFF_FF9C, 32'd9, 32'hFFFF_FFF5, 32'hFFFF_FFFF);
    repeat (32) tick();
    rst    = 1'b1;
    div_en = 1'b0;
    tick();
    rst = 1'b0;
    void'(sb.pop_back());
    check("rst_fix_complete", {31'b0, div_complete}, 32'd0);
    check("rst_fix_q", quotient, 32'd0);
    check("rst_fix_r", remainder, 32'd0);
    watchNoComplete("rst_fix", 40);

    // Recovery after reset.
    applyStimulus(1'b1, 32'd12345, 32'hFFFF_FFF5, 32'hFFFF_FB9E, 32'd3);
    checkOutput("recover", 1'b1);
    ackResult("recover");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
